nios2mypio_cpu_debug_ocimem: RTL and testbench
==============================================

NIOS2MYPIO_CPU_DEBUG_OCIMEM -- requirements
Module: nios2mypio_cpu_debug_ocimem

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning debug-RAM word-address width, legal range 4..16.
REQ-002 SHALL have parameter RAM_LATENCY, default 1, meaning read latency in cycles from ram_re to valid ram_rdata, legal range 1..3.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port jdo  input  38  JTAG debug data word from the debug-slave sysclk stage.
REQ-006 SHALL have port take_action_ocimem_a  input  1  single-cycle pulse: command/address phase.
REQ-007 SHALL have port take_action_ocimem_b  input  1  single-cycle pulse: write-data phase.
REQ-008 SHALL have port take_no_action_ocimem_a  input  1  single-cycle pulse: read-next request.
REQ-009 SHALL have port debugack  input  1  CPU halted in debug mode; RAM accesses are permitted only while high.
REQ-010 SHALL have port MonDReg  output  32  last read data, returned to the debug slave.
REQ-011 SHALL have port monitor_ready  output  1  last operation complete.
REQ-012 SHALL have port monitor_error  output  1  sticky error flag.
REQ-013 SHALL have ports ram_addr output ADDR_W, ram_wdata output 32, ram_we output 1, ram_re output 1, ram_rdata input 32: debug RAM port.

Function
REQ-014 SHALL decode command fields only on take_action_ocimem_a: jdo[35] = read request; jdo[34] = clear monitor_error; jdo[17+ADDR_W:18] = new address.
REQ-015 SHALL, on an accepted take_action_ocimem_a, load the address register MonAReg from the address field.
REQ-016 SHALL, on an accepted take_action_ocimem_a with jdo[35]=0, perform no RAM access and set monitor_ready=1 at the same edge.
REQ-017 SHALL, on an accepted take_action_ocimem_a with jdo[35]=1, read at the newly loaded address.
REQ-018 SHALL, on an accepted take_no_action_ocimem_a, read at the current MonAReg.
REQ-019 SHALL, on an accepted take_action_ocimem_b, write jdo[34:3] to the current MonAReg.
REQ-020 SHALL implement an FSM with states IDLE, WRITE and READ_WAIT; a request is accepted only when it is sampled while the state is IDLE.
REQ-021 SHALL handle an accepted write as follows: at acceptance edge E0, set state=WRITE, ram_addr=MonAReg, ram_wdata=data, ram_we=1 and monitor_ready=0.
REQ-022 SHALL complete a write at edge E1: ram_we=0, MonAReg+1, monitor_ready=1, state=IDLE; ram_we is high for exactly one cycle.
REQ-023 SHALL handle an accepted read as follows: at E0, set state=READ_WAIT, ram_addr=address, ram_re=1 and monitor_ready=0; at E1, set ram_re=0.
REQ-024 SHALL complete a read at edge E(1+RAM_LATENCY): MonDReg=ram_rdata, MonAReg+1, monitor_ready=1, state=IDLE.
REQ-025 SHALL wrap MonAReg increment modulo 2^ADDR_W, so the all-ones address wraps to 0.
REQ-026 SHALL, for any request sampled while the state is not IDLE, drop the request, set monitor_error=1 and leave the FSM undisturbed.
REQ-027 SHALL, for a read or write request with debugack=0, reject the request: no RAM strobe, monitor_error=1, monitor_ready unchanged; an address-only load (REQ-016) is still accepted.
REQ-028 SHALL resolve simultaneous pulses in IDLE by priority take_action_ocimem_a > take_action_ocimem_b > take_no_action_ocimem_a; each losing pulse sets monitor_error=1.
REQ-029 SHALL clear monitor_error via jdo[34] only on an accepted take_action_ocimem_a; an error set at the same edge has priority and monitor_error ends at 1.
REQ-030 SHALL keep ram_we and ram_re mutually exclusive and never both high.
REQ-031 SHALL keep ram_addr stable from E0 until the operation completes.

Reset
REQ-032 SHALL, while reset=1, asynchronously force: state=IDLE, MonAReg=0, MonDReg=0, monitor_ready=0, monitor_error=0, ram_addr=0, ram_wdata=0, ram_we=0, ram_re=0.
REQ-033 SHALL abort any in-flight operation on reset mid-operation: no further strobe, no MonDReg update.
REQ-034 SHALL accept a request on the first rising edge after reset deasserts.

Verification
REQ-035 SHALL be verified by this scenario: debugack=1; ocimem_a with jdo[35]=0, addr=0x10; then ocimem_b with data 0xDEADBEEF -> ram_we one cycle at addr 0x10; monitor_ready=1 at E1; MonAReg=0x11.
REQ-036 SHALL be verified by this scenario: RAM preloaded with 0x12345678 at 0x11 and RAM_LATENCY=2; ocimem_a with jdo[35]=1, addr=0x11 -> ram_re one cycle; MonDReg=0x12345678 and monitor_ready=1 at E3; MonAReg=0x12.
REQ-037 SHALL be verified by this scenario: MonAReg=0xFF with ADDR_W=8; take_no_action_ocimem_a -> read at 0xFF, then MonAReg=0x00.
REQ-038 SHALL be verified by this scenario: ocimem_b pulse while in READ_WAIT -> no ram_we, monitor_error=1, read completes normally; then ocimem_a with jdo[34]=1 -> monitor_error=0.
REQ-039 SHALL be verified by this scenario: debugack=0; ocimem_b -> no ram_we, monitor_error=1; and ocimem_a plus ocimem_b in the same cycle -> ocimem_a accepted, monitor_error=1.
REQ-040 SHALL be verified by this scenario: reset asserted one cycle after a read is accepted -> ram_re=0, MonDReg=0 and monitor_ready=0 immediately; no later MonDReg update.

Source files
------------

// File: rtl/nios2mypio_cpu_debug_ocimem.sv
// JTAG debug-RAM access engine: decodes debug-slave command pulses into
// single-word RAM reads/writes with an auto-incrementing address.
module nios2mypio_cpu_debug_ocimem #(
  parameter int ADDR_W      = 8,
  parameter int RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              debugack,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT} state_t;

  localparam logic [1:0]        LAT      = 2'(RAM_LATENCY);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_mon_a, w_mon_a_next;
  logic [31:0]       r_mon_d, w_mon_d_next;
  logic              r_ready, w_ready_next;
  logic              r_error, w_error_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [31:0]       r_wdata, w_wdata_next;
  logic              r_we, w_we_next;
  logic              r_re, w_re_next;
  logic [1:0]        r_cnt, w_cnt_next;

  logic              w_err_set;
  logic              w_err_clr;
  logic              w_any_req;
  logic [ADDR_W-1:0] w_jdo_addr;
  logic              w_unused_jdo;

  assign w_jdo_addr   = jdo[17+ADDR_W:18];
  assign w_any_req    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign w_unused_jdo = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    w_state_next = r_state;
    w_mon_a_next = r_mon_a;
    w_mon_d_next = r_mon_d;
    w_ready_next = r_ready;
    w_addr_next  = r_addr;
    w_wdata_next = r_wdata;
    w_we_next    = 1'b0;
    w_re_next    = 1'b0;
    w_cnt_next   = r_cnt;
    w_err_set    = 1'b0;
    w_err_clr    = 1'b0;

    case (r_state)
      IDLE: begin
        if (take_action_ocimem_a) begin
          if (take_action_ocimem_b | take_no_action_ocimem_a) w_err_set = 1'b1;
          if (jdo[35] && !debugack) begin
            w_err_set = 1'b1;
          end else begin
            w_mon_a_next = w_jdo_addr;
            w_err_clr    = jdo[34];
            if (jdo[35]) begin
              w_state_next = READ_WAIT;
              w_addr_next  = w_jdo_addr;
              w_re_next    = 1'b1;
              w_ready_next = 1'b0;
              w_cnt_next   = 2'd0;
            end else begin
              w_ready_next = 1'b1;
            end
          end
        end else if (take_action_ocimem_b) begin
          if (take_no_action_ocimem_a) w_err_set = 1'b1;
          if (!debugack) begin
            w_err_set = 1'b1;
          end else begin
            w_state_next = WRITE;
            w_addr_next  = r_mon_a;
            w_wdata_next = jdo[34:3];
            w_we_next    = 1'b1;
            w_ready_next = 1'b0;
          end
        end else if (take_no_action_ocimem_a) begin
          if (!debugack) begin
            w_err_set = 1'b1;
          end else begin
            w_state_next = READ_WAIT;
            w_addr_next  = r_mon_a;
            w_re_next    = 1'b1;
            w_ready_next = 1'b0;
            w_cnt_next   = 2'd0;
          end
        end
      end

      WRITE: begin
        if (w_any_req) w_err_set = 1'b1;
        w_mon_a_next = r_mon_a + ADDR_ONE;
        w_ready_next = 1'b1;
        w_state_next = IDLE;
      end

      READ_WAIT: begin
        if (w_any_req) w_err_set = 1'b1;
        // Count edges since the strobe; data is valid LAT edges after it was sampled.
        if (r_cnt == LAT) begin
          w_mon_d_next = ram_rdata;
          w_mon_a_next = r_mon_a + ADDR_ONE;
          w_ready_next = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt + 2'd1;
        end
      end

      default: w_state_next = IDLE;
    endcase

    // A fresh error outranks a clear arriving at the same edge.
    w_error_next = w_err_set ? 1'b1 : (w_err_clr ? 1'b0 : r_error);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_mon_a <= '0;
      r_mon_d <= '0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_mon_a <= w_mon_a_next;
      r_mon_d <= w_mon_d_next;
      r_ready <= w_ready_next;
      r_error <= w_error_next;
      r_addr  <= w_addr_next;
      r_wdata <= w_wdata_next;
      r_we    <= w_we_next;
      r_re    <= w_re_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign MonDReg       = r_mon_d;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;
  assign ram_addr      = r_addr;
  assign ram_wdata     = r_wdata;
  assign ram_we        = r_we;
  assign ram_re        = r_re;

endmodule

// File: tb/tb_nios2mypio_cpu_debug_ocimem.sv
// Bench for the debug-RAM engine: behavioural 2-cycle RAM, strobe scoreboard,
// and one task per scenario with inline checks.
module tb_nios2mypio_cpu_debug_ocimem;

  localparam int AW = 8;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [37:0]   jdo = '0;
  logic          pa = 1'b0, pb = 1'b0, pn = 1'b0;
  logic          debugack = 1'b0;
  logic [31:0]   MonDReg;
  logic          monitor_ready, monitor_error;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          ram_we, ram_re;
  logic [31:0]   ram_rdata = '0;

  int tests_run = 0;
  int tests_failed = 0;

  txn_t        sbq[$];
  logic [31:0] rdq[$];
  bit          pending_rd = 1'b0;
  logic [31:0] mem     [0:255];
  logic [31:0] exp_mem [0:255];
  logic [31:0] rd_stage = '0;

  always #5 clk = ~clk;

  nios2mypio_cpu_debug_ocimem #(.ADDR_W(AW), .RAM_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(pa), .take_action_ocimem_b(pb),
    .take_no_action_ocimem_a(pn), .debugack(debugack),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 'h11) return 32'h12345678;
    return 32'hA5000000 | (32'(i) * 32'h00010101);
  endfunction

  // Two-cycle registered RAM: address sampled with ram_re, data out one edge later.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_re) rd_stage <= mem[ram_addr];
      ram_rdata <= rd_stage;
    end
  end

  // Strobe monitor: pops expected accesses, then checks read data on completion.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (reset) begin
        pending_rd = 1'b0;
        rdq.delete();
      end else begin
        if (ram_we && ram_re) begin
          tests_run++; tests_failed++;
          $display("FAIL strobe_excl we=%b re=%b required not both high", ram_we, ram_re);
        end
        if (ram_we || ram_re) begin
          tests_run++;
          if (sbq.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_strobe we=%b re=%b addr=%h required no strobe", ram_we, ram_re, ram_addr);
          end else begin
            t = sbq.pop_front();
            if (t.wr !== ram_we || t.addr !== ram_addr || (t.wr && t.data !== ram_wdata)) begin
              tests_failed++;
              $display("FAIL strobe_match got we=%b addr=%h data=%h required we=%b addr=%h data=%h",
                       ram_we, ram_addr, ram_wdata, t.wr, t.addr, t.data);
            end else begin
              $display("[TB] %s addr=%h data=%h", t.wr ? "wr" : "rd", t.addr, t.data);
            end
            if (!t.wr) begin
              rdq.push_back(t.data);
              pending_rd = 1'b1;
            end
          end
        end else if (pending_rd && monitor_ready) begin
          pending_rd = 1'b0;
          tests_run++;
          if (MonDReg !== rdq[0]) begin
            tests_failed++;
            $display("FAIL rd_data got=%h required=%h", MonDReg, rdq[0]);
          end
          void'(rdq.pop_front());
        end
      end
    end
  end

  function automatic logic [37:0] cmd_a(input bit rd, input bit clr, input logic [AW-1:0] ad);
    logic [37:0] j;
    j = '0;
    j[35] = rd;
    j[34] = clr;
    j[17+AW:18] = ad;
    return j;
  endfunction

  function automatic logic [37:0] wdat(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic pulse(input bit a, input bit b, input bit n, input logic [37:0] j);
    pa = a; pb = b; pn = n; jdo = j;
    @(negedge clk);
    pa = 1'b0; pb = 1'b0; pn = 1'b0; jdo = '0;
  endtask

  task automatic push_wr(input logic [AW-1:0] ad, input logic [31:0] d);
    sbq.push_back({1'b1, ad, d});
    exp_mem[ad] = d;
  endtask

  task automatic push_rd(input logic [AW-1:0] ad);
    sbq.push_back({1'b0, ad, exp_mem[ad]});
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (monitor_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (monitor_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_timeout ready=%b required 1", tag, monitor_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({MonDReg, monitor_ready, monitor_error, ram_we, ram_re} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset_flags got MonDReg=%h rdy=%b err=%b we=%b re=%b required all 0",
               MonDReg, monitor_ready, monitor_error, ram_we, ram_re);
    end
    tests_run++;
    if (ram_addr !== '0 || ram_wdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus got addr=%h wdata=%h required 0", ram_addr, ram_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_write;
    debugack = 1'b1;
    pulse(1, 0, 0, cmd_a(0, 0, 8'h10));
    tests_run++;
    if (monitor_ready !== 1'b1 || ram_we !== 1'b0 || ram_re !== 1'b0) begin
      tests_failed++;
      $display("FAIL addr_load got rdy=%b we=%b re=%b required 1 0 0", monitor_ready, ram_we, ram_re);
    end
    push_wr(8'h10, 32'hDEADBEEF);
    pulse(0, 1, 0, wdat(32'hDEADBEEF));
    tests_run++;
    if (ram_we !== 1'b1 || ram_addr !== 8'h10 || monitor_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_e0 got we=%b addr=%h rdy=%b required 1 10 0", ram_we, ram_addr, monitor_ready);
    end
    @(negedge clk);
    tests_run++;
    if (ram_we !== 1'b0 || monitor_ready !== 1'b1 || ram_addr !== 8'h10) begin
      tests_failed++;
      $display("FAIL write_e1 got we=%b rdy=%b addr=%h required 0 1 10", ram_we, monitor_ready, ram_addr);
    end
  endtask

  task automatic test_read;
    logic [3:0] rdy_seq;
    // MonAReg is 0x11 after the previous write; the explicit read reloads it anyway.
    push_rd(8'h11);
    pulse(1, 0, 0, cmd_a(1, 0, 8'h11));
    tests_run++;
    if (ram_re !== 1'b1 || ram_addr !== 8'h11 || monitor_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_e0 got re=%b addr=%h rdy=%b required 1 11 0", ram_re, ram_addr, monitor_ready);
    end
    rdy_seq[0] = monitor_ready;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      rdy_seq[i] = monitor_ready;
    end
    tests_run++;
    if (rdy_seq !== 4'b1000 || MonDReg !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL read_latency got rdy_seq=%b data=%h required 1000 12345678", rdy_seq, MonDReg);
    end
    // Back-to-back: read-next at 0x12 then write at 0x13.
    push_rd(8'h12);
    pulse(0, 0, 1, '0);
    wait_ready("read_next");
    tests_run++;
    if (MonDReg !== exp_mem[8'h12]) begin
      tests_failed++;
      $display("FAIL read_next got=%h required=%h", MonDReg, exp_mem[8'h12]);
    end
    push_wr(8'h13, 32'h13131313);
    pulse(0, 1, 0, wdat(32'h13131313));
    wait_ready("b2b_write");
  endtask

  task automatic test_wrap;
    pulse(1, 0, 0, cmd_a(0, 0, 8'hFF));
    push_rd(8'hFF);
    pulse(0, 0, 1, '0);
    wait_ready("wrap_ff");
    push_rd(8'h00);
    pulse(0, 0, 1, '0);
    wait_ready("wrap_00");
    tests_run++;
    if (MonDReg !== exp_mem[0]) begin
      tests_failed++;
      $display("FAIL wrap_data got=%h required=%h", MonDReg, exp_mem[0]);
    end
  endtask

  task automatic test_busy_error;
    push_rd(8'h01);
    pulse(0, 0, 1, '0);
    pulse(0, 1, 0, wdat(32'hCAFEF00D));
    tests_run++;
    if (ram_we !== 1'b0 || monitor_error !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_drop got we=%b err=%b required 0 1", ram_we, monitor_error);
    end
    wait_ready("busy_read");
    tests_run++;
    if (MonDReg !== exp_mem[1]) begin
      tests_failed++;
      $display("FAIL busy_read_data got=%h required=%h", MonDReg, exp_mem[1]);
    end
    pulse(1, 0, 0, cmd_a(0, 1, 8'h40));
    tests_run++;
    if (monitor_error !== 1'b0 || monitor_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_clear got err=%b rdy=%b required 0 1", monitor_error, monitor_ready);
    end
  endtask

  task automatic test_debugack;
    debugack = 1'b0;
    pulse(0, 1, 0, wdat(32'h11112222));
    tests_run++;
    if (ram_we !== 1'b0 || monitor_error !== 1'b1 || monitor_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL nodbg_write got we=%b err=%b rdy=%b required 0 1 1", ram_we, monitor_error, monitor_ready);
    end
    pulse(0, 0, 1, '0);
    pulse(1, 0, 0, cmd_a(0, 1, 8'h50));
    tests_run++;
    if (monitor_error !== 1'b0 || monitor_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL nodbg_addr_load got err=%b rdy=%b required 0 1", monitor_error, monitor_ready);
    end
    debugack = 1'b1;
    pulse(1, 1, 0, cmd_a(0, 0, 8'h20));
    tests_run++;
    if (monitor_error !== 1'b1 || monitor_ready !== 1'b1 || ram_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL prio_a_b got err=%b rdy=%b we=%b required 1 1 0", monitor_error, monitor_ready, ram_we);
    end
    // The winning address load must have taken effect.
    push_wr(8'h20, 32'h0BADF00D);
    pulse(0, 1, 0, wdat(32'h0BADF00D));
    wait_ready("prio_write");
    pulse(1, 0, 1, cmd_a(0, 1, 8'h60));
    tests_run++;
    if (monitor_error !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_vs_set got err=%b required 1", monitor_error);
    end
    pulse(1, 0, 0, cmd_a(0, 1, 8'h11));
  endtask

  task automatic test_reset_mid;
    push_rd(8'h11);
    pulse(1, 0, 0, cmd_a(1, 0, 8'h11));
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (ram_re !== 1'b0 || MonDReg !== 32'h0 || monitor_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_abort got re=%b data=%h rdy=%b required 0 0 0", ram_re, MonDReg, monitor_ready);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_wr(8'h00, 32'h5A5A5A5A);
    pulse(0, 1, 0, wdat(32'h5A5A5A5A));
    tests_run++;
    if (ram_we !== 1'b1 || ram_addr !== 8'h00) begin
      tests_failed++;
      $display("FAIL first_edge got we=%b addr=%h required 1 00", ram_we, ram_addr);
    end
    wait_ready("post_reset_write");
    repeat (4) @(negedge clk);
    tests_run++;
    if (MonDReg !== 32'h0) begin
      tests_failed++;
      $display("FAIL no_late_update got=%h required=00000000", MonDReg);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_busy_error();
    test_debugack();
    test_reset_mid();
    repeat (2) @(negedge clk);
    tests_run++;
    if (sbq.size() != 0 || pending_rd) begin
      tests_failed++;
      $display("FAIL leftover got pending=%0d rd_pending=%b required 0 0", sbq.size(), pending_rd);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
